// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: queues received words in a FIFO and replays them to the transmitter.
// Define UART_ECHO_CRLF_EN to expand each echoed CR (8'h0D) into CR LF.
//
// state     | meaning
// IDLE      | waiting for a queued word and TXE=1
// WAIT_LOW  | WR issued, waiting for TXE to fall (or the ack timeout)
// WAIT_HIGH | transmitter busy, waiting for TXE to return high
// SEND_LF   | issuing the LF that follows an echoed CR (CRLF build only)
module uart_echo_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_W-1:0]        RX_D,
    input  logic                     RXNE,
    output logic                     RD,
    output logic [DATA_W-1:0]        TX_D,
    output logic                     WR,
    input  logic                     TXE,
    output logic [DATA_W-1:0]        LAST_RX,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [7:0]               DROP_CNT
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

`ifdef UART_ECHO_CRLF_EN
    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, SEND_LF} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;
`endif

    state_t state_q, state_d;

    logic                rxne_prev_q;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   last_rx_q, last_rx_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   tx_d_q, tx_d_d;
    logic                wr_q, wr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`ifdef UART_ECHO_CRLF_EN
    logic                is_cr_q, is_cr_d;
`endif

    logic                rx_event;
    logic                full;
    logic                push;
    logic                pop;
    logic                tx_start;
    logic [DATA_W-1:0]   head;

    assign rx_event = RXNE && !rxne_prev_q;
    // Fullness uses the pre-edge level: a same-cycle pop never makes room.
    assign full     = (level_q == LVL_W'(DEPTH));
    assign push     = rx_event && !full;
    assign tx_start = (state_q == IDLE) && (level_q != '0) && TXE;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        rd_d       = rx_event;
        last_rx_d  = last_rx_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (rx_event) begin
            last_rx_d = RX_D;
            if (full) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tx_start) state_d = WAIT_LOW;
            WAIT_LOW:  if (!TXE || tmo_q == '0) state_d = WAIT_HIGH;
            WAIT_HIGH: begin
                if (TXE) begin
`ifdef UART_ECHO_CRLF_EN
                    state_d = is_cr_q ? SEND_LF : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            SEND_LF:   state_d = WAIT_LOW;
`endif
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        wr_d   = 1'b0;
        tx_d_d = tx_d_q;
        tmo_d  = tmo_q;
`ifdef UART_ECHO_CRLF_EN
        is_cr_d = is_cr_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    pop    = 1'b1;
                    wr_d   = 1'b1;
                    tx_d_d = head;
                    tmo_d  = TMO_LOAD;
`ifdef UART_ECHO_CRLF_EN
                    is_cr_d = (head[7:0] == 8'h0D);
`endif
                end
            end
            WAIT_LOW: begin
                if (TXE && tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);
            end
`ifdef UART_ECHO_CRLF_EN
            SEND_LF: begin
                wr_d    = 1'b1;
                tx_d_d  = DATA_W'(8'h0A);
                tmo_d   = TMO_LOAD;
                is_cr_d = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxne_prev_q <= 1'b0;
            rd_q        <= 1'b0;
            last_rx_q   <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_d_q      <= '0;
            wr_q        <= 1'b0;
            tmo_q       <= '0;
`ifdef UART_ECHO_CRLF_EN
            is_cr_q     <= 1'b0;
`endif
        end else begin
            rxne_prev_q <= RXNE;
            rd_q        <= rd_d;
            last_rx_q   <= last_rx_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_d_q      <= tx_d_d;
            wr_q        <= wr_d;
            tmo_q       <= tmo_d;
`ifdef UART_ECHO_CRLF_EN
            is_cr_q     <= is_cr_d;
`endif
        end
    end

    // Storage needs no reset; emptiness is defined by the pointers and level.
    always_ff @(posedge CLK) begin
        if (!RST && push) mem_q[wr_ptr_q] <= RX_D;
    end

    assign RD       = rd_q;
    assign TX_D     = tx_d_q;
    assign WR       = wr_q;
    assign LAST_RX  = last_rx_q;
    assign LEVEL    = level_q;
    assign OVF      = ovf_q;
    assign DROP_CNT = drop_cnt_q;
endmodule
